// File: rtl/param_pe_if.sv
// param_pe_if
//   Channel bundle for the row-stationary processing element.
//   Carries the three input tile channels (filter, ifmap, ipsum) and the
//   opsum output channel, each as a data word with a valid/ready pair.
//   Ports (signals):
//     filter/ifmap/ipsum [DATA_W]   tile data words into the PE
//     *_valid / *_ready             handshake for each input channel
//     opsum [DATA_W]                accumulated psum out of the PE
//     opsum_valid / opsum_ready     handshake for the output channel
//   Modports: slave = PE side, master = producer/consumer side.
interface param_pe_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] filter;
    logic              filter_valid;
    logic              filter_ready;
    logic [DATA_W-1:0] ifmap;
    logic              ifmap_valid;
    logic              ifmap_ready;
    logic [DATA_W-1:0] ipsum;
    logic              ipsum_valid;
    logic              ipsum_ready;
    logic [DATA_W-1:0] opsum;
    logic              opsum_valid;
    logic              opsum_ready;

    modport slave (
        input  filter, filter_valid, ifmap, ifmap_valid, ipsum, ipsum_valid, opsum_ready,
        output filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
    );

    modport master (
        output filter, filter_valid, ifmap, ifmap_valid, ipsum, ipsum_valid, opsum_ready,
        input  filter_ready, ifmap_ready, ipsum_ready, opsum, opsum_valid
    );
endinterface

// File: rtl/param_pe.sv
// param_pe
//   Parametrised row-stationary processing element. Loads a filter tile,
//   an ifmap window and initial psums, runs a standard or depthwise 1-D
//   convolution row with one MAC per cycle through a pipelined signed
//   multiplier, then streams the psums out under full backpressure.
//   Ports:
//     clk       clock
//     rst       synchronous active-high reset
//     PE_en     start pulse, sampled only in IDLE
//     i_config  {depthwise, rs_m1[1:0], reserved, p_m1[1:0], F_m1[4:0], q_m1[1:0]}
//     bus       param_pe_if.slave: filter/ifmap/ipsum inputs, opsum output
//   Build option:
//     PE_SAT_ACC_EN  when defined, accumulation saturates to the signed
//                    PSUM_W range instead of wrapping.
module param_pe #(
    parameter int DATA_W       = 32,
    parameter int ELEM_W       = 8,
    parameter int PSUM_W       = 32,
    parameter int MAX_P        = 4,
    parameter int MAX_RS       = 4,
    parameter int MUL_STAGES   = 2,
    parameter int IFMAP_OFFSET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PE_en,
    input  logic [12:0] i_config,
    param_pe_if.slave   bus
);
    localparam int LANES  = DATA_W / ELEM_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam int NPS    = (MAX_P > LANES) ? MAX_P : LANES;
    localparam int FDEPTH = MAX_P * MAX_RS;
    localparam int FA_W   = $clog2(FDEPTH);
    localparam logic [ELEM_W-1:0] X_MASK =
        (IFMAP_OFFSET != 0) ? {1'b1, {(ELEM_W-1){1'b0}}} : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_F, S_LOAD_I, S_LOAD_P, S_CONV, S_DRAIN, S_WRITE
    } state_t;

    state_t r_state, w_state_next;

    logic [12:0] r_cfg;
    logic [1:0]  r_k, r_r, r_c, r_idx;
    logic [2:0]  r_drain;
    logic [4:0]  r_col;

    logic [DATA_W-1:0]        r_fmem [FDEPTH];
    logic [DATA_W-1:0]        r_xmem [MAX_RS];
    logic signed [PSUM_W-1:0] r_psum [NPS];

    logic [MUL_STAGES-1:0]    r_pv;
    logic signed [PROD_W-1:0] r_prod [MUL_STAGES];
    logic [1:0]               r_pidx [MUL_STAGES];

    // Config fields
    logic       w_dw;
    logic [1:0] w_rs_m1, w_p_m1, w_q_m1, w_nout_m1;
    logic [4:0] w_f_m1;
    assign w_dw      = r_cfg[12];
    assign w_rs_m1   = r_cfg[11:10];
    assign w_p_m1    = r_cfg[8:7];
    assign w_f_m1    = r_cfg[6:2];
    assign w_q_m1    = r_cfg[1:0];
    assign w_nout_m1 = w_dw ? w_q_m1 : w_p_m1;

    // Reserved config bit and ipsum bits above PSUM_W carry no meaning.
    logic w_unused;
    assign w_unused = &{1'b0, r_cfg[9], bus.ipsum};

    // Handshakes are qualified by state so stray valids elsewhere do nothing.
    logic w_f_hs, w_i_hs, w_p_hs, w_o_hs;
    assign w_f_hs = bus.filter_valid && (r_state == S_LOAD_F);
    assign w_i_hs = bus.ifmap_valid  && (r_state == S_LOAD_I);
    assign w_p_hs = bus.ipsum_valid  && (r_state == S_LOAD_P);
    assign w_o_hs = bus.opsum_ready  && (r_state == S_WRITE);

    logic w_f_last, w_i_last, w_p_last, w_conv_last, w_drain_last, w_o_last;
    assign w_f_last     = (r_k == w_p_m1) && (r_r == w_rs_m1);
    // The first column fills the whole window; later columns slide it by one.
    assign w_i_last     = (r_col == 5'd0) ? (r_r == w_rs_m1) : 1'b1;
    assign w_p_last     = (r_idx == w_nout_m1);
    assign w_conv_last  = w_dw ? ((r_c == w_q_m1) && (r_r == w_rs_m1))
                               : ((r_k == w_p_m1) && (r_r == w_rs_m1) && (r_c == w_q_m1));
    assign w_drain_last = (r_drain == 3'(MUL_STAGES));
    assign w_o_last     = (r_idx == w_nout_m1);

    // Operand fetch for the MAC issued this cycle
    logic [1:0]               w_fk, w_idx;
    logic [FA_W-1:0]          w_f_addr, w_ld_addr;
    logic [DATA_W-1:0]        w_f_word, w_x_word, w_x_new;
    logic signed [ELEM_W-1:0] w_f_lane [LANES];
    logic signed [ELEM_W-1:0] w_x_lane [LANES];
    logic signed [PROD_W-1:0] w_mul;

    assign w_fk      = w_dw ? 2'd0 : r_k;
    assign w_idx     = w_dw ? r_c : r_k;
    assign w_f_addr  = FA_W'(w_fk) * FA_W'(MAX_RS) + FA_W'(r_r);
    assign w_ld_addr = FA_W'(r_k) * FA_W'(MAX_RS) + FA_W'(r_r);
    assign w_f_word  = r_fmem[w_f_addr];
    assign w_x_word  = r_xmem[r_r];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        // Offset applied once at load so the spad holds signed elements.
        assign w_x_new[gi*ELEM_W +: ELEM_W] = bus.ifmap[gi*ELEM_W +: ELEM_W] ^ X_MASK;
        assign w_f_lane[gi] = w_f_word[gi*ELEM_W +: ELEM_W];
        assign w_x_lane[gi] = w_x_word[gi*ELEM_W +: ELEM_W];
    end

    assign w_mul = PROD_W'(w_f_lane[r_c]) * PROD_W'(w_x_lane[r_c]);

    // Read-modify-write accumulate from the final multiplier stage
    logic signed [PSUM_W-1:0] w_acc_a, w_prod_ext, w_acc;
    logic [PSUM_W:0]          w_sum_wide;
    assign w_acc_a    = r_psum[r_pidx[MUL_STAGES-1]];
    assign w_prod_ext = PSUM_W'(r_prod[MUL_STAGES-1]);
    assign w_sum_wide = {w_acc_a[PSUM_W-1], w_acc_a} + {w_prod_ext[PSUM_W-1], w_prod_ext};

`ifdef PE_SAT_ACC_EN
    localparam logic [PSUM_W-1:0] PS_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0] PS_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
    // Overflow when the two top bits of the widened sum disagree.
    always_comb begin
        w_acc = w_sum_wide[PSUM_W-1:0];
        if (w_sum_wide[PSUM_W] != w_sum_wide[PSUM_W-1])
            w_acc = w_sum_wide[PSUM_W] ? PS_MIN : PS_MAX;
    end
`else
    assign w_acc = w_sum_wide[PSUM_W-1:0];
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (PE_en)                w_state_next = S_LOAD_F;
            S_LOAD_F: if (w_f_hs && w_f_last)   w_state_next = S_LOAD_I;
            S_LOAD_I: if (w_i_hs && w_i_last)   w_state_next = S_LOAD_P;
            S_LOAD_P: if (w_p_hs && w_p_last)   w_state_next = S_CONV;
            S_CONV:   if (w_conv_last)          w_state_next = S_DRAIN;
            S_DRAIN:  if (w_drain_last)         w_state_next = S_WRITE;
            S_WRITE:  if (w_o_hs && w_o_last)
                          w_state_next = (r_col == w_f_m1) ? S_IDLE : S_LOAD_I;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs, all decoded from state
    always_comb begin
        bus.filter_ready = (r_state == S_LOAD_F);
        bus.ifmap_ready  = (r_state == S_LOAD_I);
        bus.ipsum_ready  = (r_state == S_LOAD_P);
        bus.opsum_valid  = (r_state == S_WRITE);
        bus.opsum        = (r_state == S_WRITE) ? DATA_W'(r_psum[r_idx]) : '0;
    end

    // Counters and config; every state returns its counters to zero on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= '0; r_k <= '0; r_r <= '0; r_c <= '0;
            r_idx <= '0; r_drain <= '0; r_col <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (PE_en) r_cfg <= i_config;
                S_LOAD_F: if (w_f_hs) begin
                    if (w_f_last) begin
                        r_k <= '0; r_r <= '0;
                    end else if (r_r == w_rs_m1) begin
                        r_r <= '0; r_k <= r_k + 2'd1;
                    end else begin
                        r_r <= r_r + 2'd1;
                    end
                end
                S_LOAD_I: if (w_i_hs) r_r <= w_i_last ? 2'd0 : r_r + 2'd1;
                S_LOAD_P: if (w_p_hs) r_idx <= w_p_last ? 2'd0 : r_idx + 2'd1;
                S_CONV: begin
                    if (w_conv_last) begin
                        r_k <= '0; r_r <= '0; r_c <= '0;
                    end else if (w_dw) begin
                        // depthwise: r inner, c outer
                        if (r_r == w_rs_m1) begin
                            r_r <= '0; r_c <= r_c + 2'd1;
                        end else begin
                            r_r <= r_r + 2'd1;
                        end
                    end else begin
                        // standard: c inner, r middle, k outer
                        if (r_c == w_q_m1) begin
                            r_c <= '0;
                            if (r_r == w_rs_m1) begin
                                r_r <= '0; r_k <= r_k + 2'd1;
                            end else begin
                                r_r <= r_r + 2'd1;
                            end
                        end else begin
                            r_c <= r_c + 2'd1;
                        end
                    end
                end
                S_DRAIN: r_drain <= w_drain_last ? 3'd0 : r_drain + 3'd1;
                S_WRITE: if (w_o_hs) begin
                    if (w_o_last) begin
                        r_idx <= '0;
                        r_col <= (r_col == w_f_m1) ? 5'd0 : r_col + 5'd1;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scratchpads: contents need no reset, they are always written before use.
    always_ff @(posedge clk) begin
        if (w_f_hs) r_fmem[w_ld_addr] <= bus.filter;
    end

    // Every ifmap beat shifts the window down and lands at row RS-1.
    always_ff @(posedge clk) begin
        if (w_i_hs) begin
            for (int i = 0; i < MAX_RS; i++) begin
                if (i == int'(w_rs_m1))  r_xmem[i] <= w_x_new;
                else if (i < MAX_RS - 1) r_xmem[i] <= r_xmem[(i < MAX_RS - 1) ? i + 1 : i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_p_hs)                      r_psum[r_idx] <= bus.ipsum[PSUM_W-1:0];
        else if (r_pv[MUL_STAGES-1])     r_psum[r_pidx[MUL_STAGES-1]] <= w_acc;
    end

    // Multiplier pipeline: valid bits reset so an aborted job leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= (r_state == S_CONV);
            for (int i = 1; i < MUL_STAGES; i++) r_pv[i] <= r_pv[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_prod[0] <= w_mul;
        r_pidx[0] <= w_idx;
        for (int i = 1; i < MUL_STAGES; i++) begin
            r_prod[i] <= r_prod[i-1];
            r_pidx[i] <= r_pidx[i-1];
        end
    end
endmodule

// File: tb/tb_param_pe.sv
// tb_param_pe: directed self-checking bench for param_pe (default parameters).
module tb_param_pe;
    logic        clk = 1'b0;
    logic        rst;
    logic        PE_en;
    logic [12:0] i_config;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] beat_buf [16];

    param_pe_if #(.DATA_W(32)) bus ();

    param_pe dut (
        .clk      (clk),
        .rst      (rst),
        .PE_en    (PE_en),
        .i_config (i_config),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] mk_cfg(input bit dw, input int rs_m1, input int p_m1,
                                           input int f_m1, input int q_m1);
        return {dw, 2'(rs_m1), 1'b0, 2'(p_m1), 5'(f_m1), 2'(q_m1)};
    endfunction

    task automatic fill(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) beat_buf[i] = v;
    endtask

    task automatic drive_ch(input int ch, input logic v, input logic [31:0] d);
        case (ch)
            0:       begin bus.filter_valid = v; bus.filter = d; end
            1:       begin bus.ifmap_valid  = v; bus.ifmap  = d; end
            default: begin bus.ipsum_valid  = v; bus.ipsum  = d; end
        endcase
    endtask

    function automatic logic ch_ready(input int ch);
        case (ch)
            0:       return bus.filter_ready;
            1:       return bus.ifmap_ready;
            default: return bus.ipsum_ready;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the last transfer edge.
    task automatic send_beats(input int ch, input int n);
        for (int b = 0; b < n; b++) begin
            bit ok;
            ok = 1'b0;
            drive_ch(ch, 1'b1, beat_buf[b]);
            for (int w = 0; w < 100; w++) begin
                if (ch_ready(ch)) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL handshake ch%0d beat %0d: ready got 0 required 1", ch, b);
                drive_ch(ch, 1'b0, '0);
                return;
            end
            @(posedge clk);
            @(negedge clk);
            drive_ch(ch, 1'b0, '0);
        end
    endtask

    task automatic start_job(input logic [12:0] cfg);
        i_config = cfg;
        PE_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        PE_en = 1'b0;
    endtask

    task automatic get_opsum(output logic [31:0] d, output bit ok);
        ok = 1'b0;
        d = '0;
        bus.opsum_ready = 1'b1;
        for (int w = 0; w < 300; w++) begin
            if (bus.opsum_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            d = bus.opsum;
            @(posedge clk);
            @(negedge clk);
        end
        bus.opsum_ready = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready, bus.opsum_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: f/i/p ready,opsum_valid got %b%b%b%b required 0000", name,
                     bus.filter_ready, bus.ifmap_ready, bus.ipsum_ready, bus.opsum_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; PE_en = 1'b0; i_config = '0;
        bus.filter_valid = 1'b0; bus.ifmap_valid = 1'b0; bus.ipsum_valid = 1'b0;
        bus.filter = '0; bus.ifmap = '0; bus.ipsum = '0; bus.opsum_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset_outputs");
        checks++;
        if (bus.opsum !== 32'h0) begin
            errors++;
            $display("FAIL reset_opsum: got %h required 00000000", bus.opsum);
        end
        // A filter beat offered in IDLE must not be taken.
        bus.filter_valid = 1'b1; bus.filter = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.filter_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_valid: filter_ready got %b required 0", bus.filter_ready);
        end
        bus.filter_valid = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_mac;
        logic [31:0] d;
        bit ok;
        start_job(mk_cfg(0, 0, 0, 0, 0));
        fill(1, 32'h00000003); send_beats(0, 1);
        fill(1, 32'h00000085); send_beats(1, 1);
        fill(1, 32'd10);       send_beats(2, 1);
        // Now in the first cycle after the ipsum edge; valid must rise in the fifth.
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) @(negedge clk);
            checks++;
            if (bus.opsum_valid !== (i == 5)) begin
                errors++;
                $display("FAIL single_latency cycle %0d: opsum_valid got %b required %b",
                         i, bus.opsum_valid, (i == 5));
            end
        end
        get_opsum(d, ok);
        checks++;
        if (!ok || d !== 32'd25) begin
            errors++;
            $display("FAIL single_mac_value: got %h (ok=%0d) required %h", d, ok, 32'd25);
        end
        check_idle("single_back_to_idle");
        $display("test_single_mac done opsum=%0d", d);
    endtask

    task automatic test_standard;
        logic [31:0] d;
        bit ok;
        start_job(mk_cfg(0, 2, 3, 1, 3));
        fill(12, 32'h01010101); send_beats(0, 12);
        fill(3, 32'h81818181);  send_beats(1, 3);
        for (int col = 0; col < 2; col++) begin
            if (col == 1) begin
                checks++;
                if (bus.ifmap_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL std_next_col_ready: ifmap_ready got %b required 1", bus.ifmap_ready);
                end
                fill(1, 32'h81818181); send_beats(1, 1);
                checks++;
                if (bus.ifmap_ready !== 1'b0 || bus.ipsum_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL std_col2_one_beat: ifmap/ipsum ready got %b%b required 01",
                             bus.ifmap_ready, bus.ipsum_ready);
                end
            end
            fill(4, 32'h0); send_beats(2, 4);
            for (int k = 0; k < 4; k++) begin
                get_opsum(d, ok);
                checks++;
                if (!ok || d !== 32'd12) begin
                    errors++;
                    $display("FAIL std_col%0d_out%0d: got %h (ok=%0d) required %h", col, k, d, ok, 32'd12);
                end
            end
        end
        check_idle("std_back_to_idle");
        $display("test_standard done");
    endtask

    task automatic test_depthwise;
        logic [31:0] d;
        bit ok;
        start_job(mk_cfg(1, 2, 0, 0, 3));
        fill(3, 32'h02020202); send_beats(0, 3);
        fill(3, 32'h83838383); send_beats(1, 3);
        fill(4, 32'd5);        send_beats(2, 4);
        for (int c = 0; c < 4; c++) begin
            get_opsum(d, ok);
            checks++;
            if (!ok || d !== 32'd23) begin
                errors++;
                $display("FAIL dw_out%0d: got %h (ok=%0d) required %h", c, d, ok, 32'd23);
            end
        end
        check_idle("dw_back_to_idle");
        $display("test_depthwise done");
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_v [4];
        int got;
        bit seen;
        exp_v[0] = 32'd12; exp_v[1] = 32'd14; exp_v[2] = 32'd16; exp_v[3] = 32'd18;
        start_job(mk_cfg(0, 0, 3, 0, 0));
        beat_buf[0] = 32'd1; beat_buf[1] = 32'd2; beat_buf[2] = 32'd3; beat_buf[3] = 32'd4;
        send_beats(0, 4);
        fill(1, 32'h00000082); send_beats(1, 1);
        fill(4, 32'd10);       send_beats(2, 4);
        bus.opsum_ready = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 100; w++) begin
            if (bus.opsum_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_valid_timeout: opsum_valid got 0 required 1");
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.opsum_valid !== 1'b1 || bus.opsum !== exp_v[0]) begin
                errors++;
                $display("FAIL bp_stall%0d: valid/opsum got %b/%h required 1/%h",
                         i, bus.opsum_valid, bus.opsum, exp_v[0]);
            end
            @(negedge clk);
        end
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            bus.opsum_ready = ((cyc % 2) == 0);
            checks++;
            if (bus.opsum_valid !== 1'b1 || bus.opsum !== exp_v[got]) begin
                errors++;
                $display("FAIL bp_out%0d: valid/opsum got %b/%h required 1/%h",
                         got, bus.opsum_valid, bus.opsum, exp_v[got]);
            end
            if (bus.opsum_ready) got++;
            @(negedge clk);
        end
        bus.opsum_ready = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs required 4", got);
        end
        check_idle("bp_back_to_idle");
        $display("test_backpressure done");
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic [31:0] exp_d;
        bit ok;
`ifdef PE_SAT_ACC_EN
        exp_d = 32'h7FFFFFFF;
`else
        exp_d = 32'h80003EF1;
`endif
        start_job(mk_cfg(0, 0, 0, 0, 0));
        fill(1, 32'h0000007F); send_beats(0, 1);
        fill(1, 32'h000000FF); send_beats(1, 1);
        fill(1, 32'h7FFFFFF0); send_beats(2, 1);
        get_opsum(d, ok);
        checks++;
        if (!ok || d !== exp_d) begin
            errors++;
            $display("FAIL overflow: got %h (ok=%0d) required %h", d, ok, exp_d);
        end
        $display("test_overflow done opsum=%h", d);
    endtask

    task automatic test_reset_mid_conv;
        bit stray;
        start_job(mk_cfg(0, 2, 3, 0, 3));
        fill(12, 32'h01010101); send_beats(0, 12);
        fill(3, 32'h81818181);  send_beats(1, 3);
        fill(4, 32'h0);         send_beats(2, 4);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_mid_conv");
        stray = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.opsum_valid) stray = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rst_no_stray_output: opsum_valid got 1 required 0");
        end
        test_single_mac();
        $display("test_reset_mid_conv done");
    endtask

    initial begin
        test_reset();
        test_single_mac();
        test_standard();
        test_depthwise();
        test_backpressure();
        test_overflow();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_pe.md
# param_pe

Parametrised successor of the row-stationary processing element in the PE array. It has configurable operand, psum and lane widths, scratchpad depths and multiplier pipeline depth. It loads filter, ifmap and ipsum tiles over valid/ready channels, then runs a standard or depthwise 1-D convolution row. It issues one MAC per cycle through a pipelined signed multiplier and streams the accumulated psums out with full backpressure support.

## Interface
- `DATA_W`, 32: width of each ifmap/filter/ipsum/opsum channel word.
- `ELEM_W`, 8: ifmap/filter element width; `LANES = DATA_W/ELEM_W` elements per beat.
- `PSUM_W`, 32: accumulator width; must be ≤ `DATA_W`.
- `MAX_P`, 4: maximum output channels, which is also the psum spad depth.
- `MAX_RS`, 4: maximum filter width; ifmap spad holds `MAX_RS*LANES` elements.
- `MUL_STAGES`, 2: multiplier pipeline registers, range 1..4.
- `IFMAP_OFFSET`, 1: 1 means each incoming ifmap element is XORed with `1<<(ELEM_W-1)` (uint to int); 0 means no change.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `PE_en` in 1: start pulse; sampled only in IDLE.
- `i_config` in 13: configuration word, latched when `PE_en` is sampled in IDLE.
  - [12] depthwise.
  - [11:10] rs_m1.
  - [9] reserved.
  - [8:7] p_m1.
  - [6:2] F_m1 (output columns − 1).
  - [1:0] q_m1.
- `ifmap`/`filter`/`ipsum` in `DATA_W`: input data channels.
- `ifmap_valid`/`filter_valid`/`ipsum_valid` in 1: input valids.
- `ifmap_ready`/`filter_ready`/`ipsum_ready` out 1: input readies.
- `opsum` out `DATA_W`: output psum, sign-extended from `PSUM_W`.
- `opsum_valid` out 1: output valid.
- `opsum_ready` in 1: output ready.

## Operation
- A beat transfers on any channel when valid and ready are both high.
- Readies are decoded from state, never from valid: `filter_ready` is high only in LOAD_F, `ifmap_ready` only in LOAD_I, `ipsum_ready` only in LOAD_P.
- Derived values: P=p_m1+1, Q=q_m1+1 (Q ≤ LANES), RS=rs_m1+1, N_OUT = depthwise ? Q : P.
- States: IDLE → LOAD_F → LOAD_I → LOAD_P → CONV → DRAIN → WRITE → (LOAD_I | IDLE).
- IDLE: when `PE_en`=1, latch config and go to LOAD_F.
- LOAD_F: accept P*RS beats; each beat holds lanes c=0..LANES-1 for one (k,r). Then go to LOAD_I.
- LOAD_I:
  - First column: accept RS beats.
  - Later columns: accept exactly 1 beat. The window shifts, the oldest row r=0 is dropped and the new beat becomes r=RS-1.
  - Then go to LOAD_P.
- LOAD_P: accept N_OUT beats. Beat j initialises psum[j] from `ipsum[PSUM_W-1:0]`. Then go to CONV.
- CONV issues one MAC per cycle:
  - Standard: loop k in 0..P-1, r in 0..RS-1, c in 0..Q-1; psum[k] += f[k][r][c]*x[r][c]. Total P*RS*Q cycles.
  - Depthwise: loop c in 0..Q-1, r in 0..RS-1; psum[c] += f[0][r][c]*x[r][c]. Total Q*RS cycles.
- Multiplier: signed `ELEM_W`×`ELEM_W`, registered `MUL_STAGES` times. Accumulation is a single-cycle read-modify-write in the final stage, so back-to-back MACs to the same psum entry have no hazard.
- Accumulation: product is sign-extended to `PSUM_W`; the add wraps modulo 2^`PSUM_W`, except as changed under Configuration.
- DRAIN: lasts `MUL_STAGES`+1 cycles, until the pipeline is empty.
- WRITE: present psum[0..N_OUT-1] in order. `opsum` and `opsum_valid` are held stable until accepted.
  - After the last beat is accepted, go to IDLE if col_cnt==F_m1; otherwise increment col_cnt and go to LOAD_I.
- `PE_en` and every input valid are ignored outside their state.
- Reset:
  - Clears state to IDLE, and clears all counters, col_cnt, pipeline valid bits and the config register.
  - Outputs after reset: all readies 0, `opsum_valid` 0, `opsum` 0.
  - Spad contents are don't-care; they are always rewritten before being read.
  - A reset in any state, including mid-CONV or mid-WRITE, aborts the job with no stray accumulate or output afterwards.

## Timing
- Readies rise in the first cycle of their state. A load state is left on the clock edge of its final accepted beat.
- Let the last ipsum beat be accepted at edge t and N = MAC count. Then:
  - CONV occupies cycles t+1..t+N.
  - DRAIN occupies cycles t+N+1..t+N+MUL_STAGES+1.
  - `opsum_valid` first goes high in cycle t+N+MUL_STAGES+2.
- At full throughput, WRITE outputs one opsum per cycle. `opsum_ready` low stalls WRITE indefinitely with no loss.
- In the cycle after the final opsum handshake, the ready of the next state is asserted.

## Configuration
- `PE_SAT_ACC_EN` defined: every accumulate and every ipsum-plus-product saturates to [−2^(PSUM_W−1), 2^(PSUM_W−1)−1].
- `PE_SAT_ACC_EN` undefined: two's-complement wrap. Latency is identical either way.

## Test plan
- Single MAC, default params, P=Q=RS=1, F_m1=0. Send filter 0x00000003, ifmap 0x00000085 (becomes +5), ipsum 10 → opsum 25. `opsum_valid` must rise exactly 5 cycles after the ipsum edge. Then return to IDLE.
- Standard mode, P=Q=4, RS=3, F_m1=1. Filter beats 0x01010101, ifmap beats 0x81818181, ipsum 0 → four opsums of 12 per column. Column 2 must accept exactly 1 ifmap beat.
- Depthwise, Q=4, RS=3. Filter 0x02020202 ×3, ifmap 0x83838383, ipsum 5 → four opsums of 23.
- Backpressure: hold `opsum_ready`=0 for 5 cycles, then toggle it 1/0. Require `opsum` and `opsum_valid` stable while stalled, 4 outputs in order, none dropped or duplicated.
- Overflow: ipsum 0x7FFFFFF0, filter 0x7F, ifmap 0xFF (becomes +127) → opsum 0x7FFFFFFF with `PE_SAT_ACC_EN`, 0x80003EF1 without it.
- Assert `rst` for 1 cycle mid-CONV. The next cycle must show all readies=0 and `opsum_valid`=0. A following single-MAC job must then give 25.
